// File: rtl/vs_arb_pkg.sv
// Shared types, default widths and the rotate-priority helper for the vSwitch output arbiter.
// The helper works on a fixed 8-input vector so any NUM_VS in 2..8 can reuse it.
package vs_arb_pkg;

  localparam int MAX_VS       = 8;
  localparam int DEF_NUM_VS   = 4;
  localparam int DEF_DATA_W   = 256;
  localparam int DEF_TUSER_W  = 128;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // First requester after 'last', wrapping modulo n; returns 'last' when nobody requests.
  function automatic logic [2:0] next_rr(input logic [MAX_VS-1:0] req,
                                         input logic [2:0]        last,
                                         input int                n);
    int   cand;
    logic found;
    next_rr = last;
    found   = 1'b0;
    for (int k = 1; k <= MAX_VS; k++) begin
      cand = (int'(last) + k) % n;
      if (k <= n && !found && req[cand[2:0]]) begin
        next_rr = cand[2:0];
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/vs_output_arbiter_rr.sv
// Purpose: combinational rotate-priority encoder picking the next vSwitch to serve.
// Latency: none, pure logic.
// Backpressure: none, it only looks at request levels.
module rr_arbiter
  import vs_arb_pkg::*;
#(
  parameter int NUM_VS  = DEF_NUM_VS,
  parameter int GRANT_W = $clog2(NUM_VS)
) (
  input  logic [NUM_VS-1:0]  req,
  input  logic [GRANT_W-1:0] last_grant,
  output logic [GRANT_W-1:0] gnt_idx,
  output logic               any_req
);

  assign gnt_idx = GRANT_W'(next_rr(MAX_VS'(req), 3'(last_grant), NUM_VS));
  assign any_req = |req;

endmodule

// File: rtl/vs_output_arbiter.sv
// Purpose: packet-atomic round-robin merge of NUM_VS AXI4-Stream inputs onto one output.
// Latency: one arbitration cycle before each packet, then zero-cycle passthrough.
// Backpressure: m_axis_tready is routed only to the granted input's s_axis_tready.
module vs_output_arbiter
  import vs_arb_pkg::*;
#(
  parameter int NUM_VS             = DEF_NUM_VS,
  parameter int C_AXIS_DATA_WIDTH  = DEF_DATA_W,
  parameter int C_AXIS_TUSER_WIDTH = DEF_TUSER_W,
  parameter int GRANT_W            = $clog2(NUM_VS)
) (
  input  logic                                 axis_aclk,
  input  logic                                 axis_resetn,
  input  logic [NUM_VS*C_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_VS*C_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [NUM_VS*C_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic [NUM_VS-1:0]                    s_axis_tvalid,
  input  logic [NUM_VS-1:0]                    s_axis_tlast,
  output logic [NUM_VS-1:0]                    s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]       m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]        m_axis_tuser,
  output logic                                 m_axis_tvalid,
  output logic                                 m_axis_tlast,
  input  logic                                 m_axis_tready,
  output logic [GRANT_W-1:0]                   grant_id,
  output logic                                 busy
);

  localparam int KEEP_W = C_AXIS_DATA_WIDTH / 8;

  arb_state_t         state, state_nxt;
  logic [GRANT_W-1:0] grant_nxt;
  logic [GRANT_W-1:0] last_grant, last_nxt;
  logic [GRANT_W-1:0] gnt_idx;
  logic               any_req;

  rr_arbiter #(
    .NUM_VS  (NUM_VS),
    .GRANT_W (GRANT_W)
  ) u_rr (
    .req        (s_axis_tvalid),
    .last_grant (last_grant),
    .gnt_idx    (gnt_idx),
    .any_req    (any_req)
  );

  // last_grant starts at the top index so input 0 wins the first arbitration.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= GRANT_W'(NUM_VS - 1);
    end else begin
      state      <= state_nxt;
      grant_id   <= grant_nxt;
      last_grant <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    last_nxt  = last_grant;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = BUSY;
          grant_nxt = gnt_idx;
        end
      end
      BUSY: begin
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
          state_nxt = IDLE;
          last_nxt  = grant_id;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output and ready muxes; everything reads as zero while idle.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tuser  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state == BUSY) begin
      for (int i = 0; i < NUM_VS; i++) begin
        if (GRANT_W'(i) == grant_id) begin
          m_axis_tdata     = s_axis_tdata[i*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
          m_axis_tkeep     = s_axis_tkeep[i*KEEP_W +: KEEP_W];
          m_axis_tuser     = s_axis_tuser[i*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
          m_axis_tvalid    = s_axis_tvalid[i];
          m_axis_tlast     = s_axis_tlast[i];
          s_axis_tready[i] = m_axis_tready;
        end
      end
    end
  end

  assign busy = (state == BUSY);

endmodule

// File: tb/tb_vs_output_arbiter.sv
// Directed bench for vs_output_arbiter: per-input beat queues feed the DUT,
// a scoreboard of expected beats is checked as the merged stream emerges.
module tb_vs_output_arbiter;

  localparam int NV = 4;
  localparam int DW = 32;
  localparam int UW = 16;
  localparam int KW = DW / 8;
  localparam int GW = 2;

  typedef struct packed {
    logic          last;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct packed {
    logic [GW-1:0] src;
    beat_t         b;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NV*DW-1:0] s_tdata;
  logic [NV*KW-1:0] s_tkeep;
  logic [NV*UW-1:0] s_tuser;
  logic [NV-1:0]    s_tvalid;
  logic [NV-1:0]    s_tlast;
  logic [NV-1:0]    s_tready;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic [UW-1:0]    m_tuser;
  logic             m_tvalid;
  logic             m_tlast;
  logic             m_tready;
  logic [GW-1:0]    grant_id;
  logic             busy;

  vs_output_arbiter #(
    .NUM_VS             (NV),
    .C_AXIS_DATA_WIDTH  (DW),
    .C_AXIS_TUSER_WIDTH (UW)
  ) dut (
    .axis_aclk     (clk),
    .axis_resetn   (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  beat_t in_q [NV][$];
  exp_t  exp_q[$];
  int    out_cyc[$];
  int    cyc    = 0;
  int    n_vec  = 0;
  int    n_err  = 0;
  int    c0     = 0;
  logic  chk_rdy = 1'b0;
  logic  tgl     = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NV; i++) begin
      if (in_q[i].size() > 0) begin
        s_tvalid[i]          = 1'b1;
        s_tlast[i]           = in_q[i][0].last;
        s_tdata[i*DW +: DW]  = in_q[i][0].data;
        s_tkeep[i*KW +: KW]  = in_q[i][0].keep;
        s_tuser[i*UW +: UW]  = in_q[i][0].user;
      end else begin
        s_tvalid[i]          = 1'b0;
        s_tlast[i]           = 1'b0;
        s_tdata[i*DW +: DW]  = '0;
        s_tkeep[i*KW +: KW]  = '0;
        s_tuser[i*UW +: UW]  = '0;
      end
    end
  endtask

  task automatic load(input int src, input int pkt, input int nb);
    beat_t b;
    exp_t  e;
    for (int j = 0; j < nb; j++) begin
      b.data = {8'(src), 8'(pkt), 16'(j)};
      b.user = {4'(src), 4'(pkt), 8'(j)} ^ 16'h5a00;
      b.last = (j == nb - 1);
      b.keep = (j == nb - 1) ? 4'b0111 : 4'hf;
      in_q[src].push_back(b);
      e.src = GW'(src);
      e.b   = b;
      exp_q.push_back(e);
    end
    drive();
  endtask

  // One clock: sample mid-cycle, compare any accepted beat, then advance and re-drive.
  task automatic step();
    logic [NV-1:0] hs;
    exp_t          e;
    #1;
    hs = s_tvalid & s_tready;
    if (chk_rdy)
      chk("rdy_track", 64'(s_tready),
          (cyc > c0 && exp_q.size() > 0) ? 64'({2'b00, m_tready, 1'b0}) : 64'(0));
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 64'(m_tvalid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("tdata", 64'(m_tdata), 64'(e.b.data));
        chk("tkeep", 64'(m_tkeep), 64'(e.b.keep));
        chk("tuser", 64'(m_tuser), 64'(e.b.user));
        chk("tlast", 64'(m_tlast), 64'(e.b.last));
        chk("grant_id", 64'(grant_id), 64'(e.src));
        out_cyc.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NV; i++)
      if (hs[i]) void'(in_q[i].pop_front());
    if (tgl) m_tready = ~m_tready;
    drive();
  endtask

  task automatic run_until_empty(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    rst_n    = 1'b0;
    m_tready = 1'b1;
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_m_tlast", 64'(m_tlast), 64'(0));
    chk("rst_m_tdata", 64'(m_tdata), 64'(0));
    chk("rst_m_tkeep", 64'(m_tkeep), 64'(0));
    chk("rst_m_tuser", 64'(m_tuser), 64'(0));
    chk("rst_s_tready", 64'(s_tready), 64'(0));
    chk("rst_grant_id", 64'(grant_id), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;

    // Idle with no requests.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_m_tvalid", 64'(m_tvalid), 64'(0));
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_s_tready", 64'(s_tready), 64'(0));
    end

    // All four inputs present a 4-beat packet at once: served 0,1,2,3 with one bubble each.
    out_cyc.delete();
    c0 = cyc;
    for (int s = 0; s < NV; s++) load(s, 1, 4);
    run_until_empty("rr4_done", 60);
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++)
        chk("rr4_cycle", 64'(out_cyc[4*k+j]), 64'(c0 + 1 + 5*k + j));

    // Input 2 alone, three single-beat packets back to back.
    out_cyc.delete();
    c0 = cyc;
    for (int p = 0; p < 3; p++) load(2, 2 + p, 1);
    run_until_empty("single_done", 30);
    for (int k = 0; k < 3; k++)
      chk("single_cycle", 64'(out_cyc[k]), 64'(c0 + 1 + 2*k));

    // Backpressure on a 6-beat packet from input 1.
    out_cyc.delete();
    m_tready = 1'b1;
    c0       = cyc;
    chk_rdy  = 1'b1;
    tgl      = 1'b1;
    load(1, 5, 6);
    run_until_empty("bp_done", 40);
    chk("bp_beats", 64'(out_cyc.size()), 64'(6));
    chk_rdy  = 1'b0;
    tgl      = 1'b0;
    m_tready = 1'b1;

    // Fairness: input 3 joins while input 0 streams; it goes right after input 0's current packet.
    out_cyc.delete();
    c0 = cyc;
    load(0, 6, 2);
    step();
    load(3, 7, 2);
    load(0, 8, 2);
    load(0, 9, 2);
    run_until_empty("fair_done", 40);
    chk("fair_in3_cycle", 64'(out_cyc[2]), 64'(c0 + 4));

    // Asynchronous reset in the middle of an 8-beat packet from input 2.
    out_cyc.delete();
    load(2, 10, 8);
    for (int n = 0; n < 20 && out_cyc.size() < 3; n++) step();
    chk("mid_beats_before_rst", 64'(out_cyc.size()), 64'(3));
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("arst_s_tready", 64'(s_tready), 64'(0));
    chk("arst_grant_id", 64'(grant_id), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NV; i++) in_q[i].delete();
    exp_q.delete();
    out_cyc.delete();
    rst_n = 1'b1;
    c0    = cyc;
    load(0, 11, 1);
    load(2, 12, 1);
    run_until_empty("post_rst_done", 20);
    chk("post_rst_first_cycle", 64'(out_cyc[0]), 64'(c0 + 1));
    chk("post_rst_second_cycle", 64'(out_cyc[1]), 64'(c0 + 3));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
